et_gate: RTL and testbench

Eligibility-time gate for the ATS (IEEE 802.1Qcr) path. It sits directly downstream of the eligibility-time/deadline stage. For each frame it takes one eligibility timestamp, holds the frame until the local clock `current_time` reaches that timestamp, then forwards the frame unmodified through a registered AXI4-Stream slice. Frames with a zero eligibility time are already discarded upstream, so every timestamp received here is valid.

---
 rtl/et_gate_if.sv | 26 ++
 rtl/et_gate.sv | 126 ++++++++++++
 tb/tb_et_gate.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/et_gate_if.sv
// Stream interfaces for the eligibility-time gate: a frame stream and a timestamp stream.

interface et_gate_axis_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KEEP_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

interface et_gate_ts_if #(
    parameter int unsigned TS_W = 72
);
    logic [TS_W-1:0] tdata;
    logic            tvalid;
    logic            tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/et_gate.sv
// Eligibility-time gate: holds each frame until current_time reaches its
// eligibility timestamp, then forwards it through a registered stream slice.

module et_gate #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
    parameter int unsigned C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int unsigned TIMESTAMP_WIDTH    = 72
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [TIMESTAMP_WIDTH-1:0] current_time,
    et_gate_axis_if.slave              s_axis,
    et_gate_ts_if.slave                s_axis_timestamp,
    et_gate_axis_if.master             m_axis,
    output logic                       hold_active,
    output logic [31:0]                stat_frames
);

    localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
    localparam int unsigned KW = C_AXIS_TKEEP_WIDTH;
    localparam int unsigned TW = TIMESTAMP_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_PASS = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_et;
    logic            r_hold_active;
    logic [DW-1:0]   r_tdata;
    logic [KW-1:0]   r_tkeep;
    logic            r_tvalid;
    logic            r_tlast;
    logic [31:0]     r_stat;

    logic [TW-1:0]   w_diff;
    logic            w_eligible;
    logic            w_ts_ready;
    logic            w_ts_hs;
    logic            w_s_ready;
    logic            w_s_hs;
    logic            w_m_hs;

    // Wrap-safe "current_time >= et": the modular difference is non-negative.
    assign w_diff     = current_time - r_et;
    assign w_eligible = ~w_diff[TW-1];

    // Handshake decode; the input beat path only opens in PASS when the slice can take it.
    assign w_ts_ready = (r_state == S_IDLE);
    assign w_ts_hs    = w_ts_ready && s_axis_timestamp.tvalid;
    assign w_s_ready  = (r_state == S_PASS) && (!r_tvalid || m_axis.tready);
    assign w_s_hs     = w_s_ready && s_axis.tvalid;
    assign w_m_hs     = r_tvalid && m_axis.tready;

    // Gate state machine: wait for a timestamp, hold until eligible, pass one frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_et          <= '0;
            r_hold_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ts_hs) begin
                        r_et          <= s_axis_timestamp.tdata;
                        r_state       <= S_HOLD;
                        r_hold_active <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_eligible) begin
                        r_state       <= S_PASS;
                        r_hold_active <= 1'b0;
                    end
                end
                S_PASS: begin
                    if (w_s_hs && s_axis.tlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_hold_active <= 1'b0;
                end
            endcase
        end
    end

    // Output slice: load on input beat, drop valid once consumed, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_s_hs) begin
            r_tdata  <= s_axis.tdata;
            r_tkeep  <= s_axis.tkeep;
            r_tvalid <= 1'b1;
            r_tlast  <= s_axis.tlast;
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end

    // Forwarded-frame counter, stepped on each last-beat output handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat <= '0;
        end else if (w_m_hs && r_tlast) begin
            r_stat <= r_stat + 32'd1;
        end
    end

    assign s_axis.tready           = w_s_ready;
    assign s_axis_timestamp.tready = w_ts_ready;
    assign m_axis.tdata            = r_tdata;
    assign m_axis.tkeep            = r_tkeep;
    assign m_axis.tvalid           = r_tvalid;
    assign m_axis.tlast            = r_tlast;
    assign hold_active             = r_hold_active;
    assign stat_frames             = r_stat;

endmodule

// File: tb/tb_et_gate.sv
// Directed bench for et_gate: table of timestamp/frame scenarios plus
// hand-written back-to-back and mid-frame reset sequences.

module tb_et_gate;

    localparam int unsigned DW = 8;
    localparam int unsigned KW = 1;
    localparam int unsigned TW = 72;

    logic          clk;
    logic          rstn;
    logic [TW-1:0] ct;
    logic          hold_active;
    logic [31:0]   stat_frames;
    bit            ct_inc;

    et_gate_axis_if #(.DATA_W(DW), .KEEP_W(KW)) s_if ();
    et_gate_axis_if #(.DATA_W(DW), .KEEP_W(KW)) m_if ();
    et_gate_ts_if   #(.TS_W(TW))                ts_if ();

    et_gate #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_AXIS_TKEEP_WIDTH(KW),
        .TIMESTAMP_WIDTH   (TW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .current_time    (ct),
        .s_axis          (s_if.slave),
        .s_axis_timestamp(ts_if.slave),
        .m_axis          (m_if.master),
        .hold_active     (hold_active),
        .stat_frames     (stat_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] ct0;
        bit            inc;
        logic [TW-1:0] ts;
        int            nbeats;
        logic [7:0]    base;
        int            bp;
        int            exp_hold;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];
    int   n_vec;
    int   n_err;
    int   exp_frames;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bdat(input logic [7:0] base, input int k);
        return base + 8'(k * 17);
    endfunction

    function automatic logic rdy(input int bp, input int c);
        if (bp == 0) return 1'b1;
        return (c % 3) == 0;
    endfunction

    task automatic idle_inputs();
        ts_if.tvalid = 1'b0;
        ts_if.tdata  = '0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tkeep   = '0;
        s_if.tlast   = 1'b0;
        m_if.tready  = 1'b1;
    endtask

    // One timestamp + one frame, measuring hold time, first accept and first output valid.
    task automatic run_frame(input int idx, input vec_t v);
        int cyc, out_idx, beat, hold, first_valid, first_acc, viol;
        bit wt, ws, wm;
        cyc = 0; out_idx = 0; beat = 0; hold = 0;
        first_valid = -1; first_acc = -1; viol = 0;
        ct            = v.ct0;
        ct_inc        = v.inc;
        ts_if.tdata   = v.ts;
        ts_if.tvalid  = 1'b1;
        s_if.tdata    = bdat(v.base, 0);
        s_if.tkeep    = 1'b1;
        s_if.tlast    = (v.nbeats == 1);
        s_if.tvalid   = 1'b1;
        m_if.tready   = rdy(v.bp, 0);
        while (out_idx < v.nbeats && cyc < 400) begin
            #1;
            wt = ts_if.tvalid && ts_if.tready;
            ws = s_if.tvalid && s_if.tready;
            wm = m_if.tvalid && m_if.tready;
            if (m_if.tvalid && !m_if.tready && s_if.tready) viol++;
            if (hold_active && (s_if.tready || ts_if.tready)) viol++;
            if (wm) begin
                chk($sformatf("v%0d_data%0d", idx, out_idx), 72'(m_if.tdata), 72'(bdat(v.base, out_idx)));
                chk($sformatf("v%0d_last%0d", idx, out_idx), 72'(m_if.tlast), 72'(out_idx == v.nbeats - 1));
                out_idx++;
            end
            @(posedge clk);
            #1;
            if (ws && first_acc < 0) first_acc = cyc;
            cyc++;
            if (ct_inc) ct = ct + 72'd1;
            if (wt) ts_if.tvalid = 1'b0;
            if (ws) begin
                beat++;
                if (beat < v.nbeats) begin
                    s_if.tdata = bdat(v.base, beat);
                    s_if.tlast = (beat == v.nbeats - 1);
                end else begin
                    s_if.tvalid = 1'b0;
                    s_if.tlast  = 1'b0;
                end
            end
            if (hold_active) hold++;
            if (first_valid < 0 && m_if.tvalid) first_valid = cyc;
            m_if.tready = rdy(v.bp, cyc);
        end
        ct_inc = 1'b0;
        exp_frames++;
        chk($sformatf("v%0d_timeout", idx), 72'(cyc < 400), 72'd1);
        chk($sformatf("v%0d_hold", idx), 72'(hold), 72'(v.exp_hold));
        chk($sformatf("v%0d_first_acc", idx), 72'(first_acc), 72'(v.exp_hold + 1));
        chk($sformatf("v%0d_latency", idx), 72'(first_valid), 72'(v.exp_lat));
        chk($sformatf("v%0d_protocol", idx), 72'(viol), 72'd0);
        chk($sformatf("v%0d_drained", idx), 72'(m_if.tvalid), 72'd0);
        chk($sformatf("v%0d_stat", idx), 72'(stat_frames), 72'(exp_frames));
        m_if.tready = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_tvalid"}, 72'(m_if.tvalid), 72'd0);
        chk({tag, "_tlast"},  72'(m_if.tlast),  72'd0);
        chk({tag, "_tdata"},  72'(m_if.tdata),  72'd0);
        chk({tag, "_tkeep"},  72'(m_if.tkeep),  72'd0);
        chk({tag, "_hold"},   72'(hold_active), 72'd0);
        chk({tag, "_stat"},   72'(stat_frames), 72'd0);
        chk({tag, "_ts_rdy"}, 72'(ts_if.tready), 72'd1);
        chk({tag, "_s_rdy"},  72'(s_if.tready), 72'd0);
    endtask

    initial begin
        logic [7:0] b2b_dat [4];
        int         ts_c [2];
        int         acc_c [4];
        logic [7:0] out_v [4];
        int         nts, nacc, nout, cnt;
        bit         wt, ws, wm;

        n_vec = 0; n_err = 0; exp_frames = 0;
        ct_inc = 1'b0;
        ct = '0;
        rstn = 1'b0;
        idle_inputs();

        //       ct0                  inc  ts                   nb base   bp hold lat
        vecs[0] = '{72'd1000,          0, 72'd500,              4, 8'h11, 0, 1,  3};
        vecs[1] = '{72'd100,           1, 72'd150,              2, 8'hA0, 0, 50, 52};
        vecs[2] = '{{72{1'b1}} - 72'd9, 1, 72'd5,               3, 8'h30, 0, 15, 17};
        vecs[3] = '{{72{1'b1}} - 72'd9, 1, {72{1'b1}} - 72'd19, 2, 8'h50, 0, 1,  3};
        vecs[4] = '{72'd1000,          0, 72'd1000,             1, 8'h77, 0, 1,  3};
        vecs[5] = '{72'd300,           1, 72'd302,              3, 8'h21, 1, 2,  4};
        vecs[6] = '{72'd0,             1, 72'd1,                3, 8'h61, 1, 1,  3};

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_frame(i, vecs[i]);

        // Back-to-back: two 2-beat frames, second timestamp offered continuously.
        b2b_dat[0] = 8'hB1; b2b_dat[1] = 8'hB2; b2b_dat[2] = 8'hC1; b2b_dat[3] = 8'hC2;
        for (int i = 0; i < 4; i++) begin acc_c[i] = -1; out_v[i] = '0; end
        ts_c[0] = -1; ts_c[1] = -1;
        nts = 0; nacc = 0; nout = 0;
        ct = 72'd50;
        ts_if.tdata = 72'd10; ts_if.tvalid = 1'b1;
        s_if.tdata = b2b_dat[0]; s_if.tkeep = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
        m_if.tready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            wt = ts_if.tvalid && ts_if.tready;
            ws = s_if.tvalid && s_if.tready;
            wm = m_if.tvalid && m_if.tready;
            if (wm && nout < 4) begin out_v[nout] = m_if.tdata; nout++; end
            if (wt && nts < 2) ts_c[nts] = c;
            if (ws && nacc < 4) acc_c[nacc] = c;
            @(posedge clk);
            #1;
            if (wt) begin
                nts++;
                if (nts == 1) ts_if.tdata = 72'd20;
                else ts_if.tvalid = 1'b0;
            end
            if (ws) begin
                nacc++;
                if (nacc < 4) begin
                    s_if.tdata = b2b_dat[nacc];
                    s_if.tlast = (nacc == 1) || (nacc == 3);
                end else begin
                    s_if.tvalid = 1'b0;
                    s_if.tlast  = 1'b0;
                end
            end
        end
        exp_frames += 2;
        chk("b2b_ts0_cyc", 72'(ts_c[0]), 72'd0);
        chk("b2b_ts1_cyc", 72'(ts_c[1]), 72'd4);
        chk("b2b_acc0", 72'(acc_c[0]), 72'd2);
        chk("b2b_acc1", 72'(acc_c[1]), 72'd3);
        chk("b2b_acc2", 72'(acc_c[2]), 72'd6);
        chk("b2b_acc3", 72'(acc_c[3]), 72'd7);
        chk("b2b_nout", 72'(nout), 72'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("b2b_out%0d", i), 72'(out_v[i]), 72'(b2b_dat[i]));
        chk("b2b_stat", 72'(stat_frames), 72'(exp_frames));

        // Reset mid-frame: drop rstn after the second of four input beats.
        idle_inputs();
        ct = 72'd1000;
        ts_if.tdata = 72'd900; ts_if.tvalid = 1'b1;
        s_if.tdata = 8'hD0; s_if.tkeep = 1'b1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
        nacc = 0; cnt = 0;
        while (nacc < 2 && cnt < 50) begin
            #1;
            wt = ts_if.tvalid && ts_if.tready;
            ws = s_if.tvalid && s_if.tready;
            @(posedge clk);
            #1;
            cnt++;
            if (wt) ts_if.tvalid = 1'b0;
            if (ws) begin nacc++; s_if.tdata = 8'hD0 + 8'(nacc); end
        end
        chk("mid_reached_beat2", 72'(nacc), 72'd2);
        chk("mid_out_valid_before_rst", 72'(m_if.tvalid), 72'd1);
        idle_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("mid");
        rstn = 1'b1;
        exp_frames = 0;
        run_frame(7, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
